full_subtractor_unit: RTL and testbench

- Registered, parameterizable-width full subtractor: computes diff = a - b - bin and the borrow-out bout.
- WIDTH=1 (default) is the classic single-bit full subtractor cell. Wider instances chain WIDTH cells in a ripple-borrow arrangement.
- Sits in datapaths that need a registered subtract-with-borrow stage. bout cascades into the bin of the next, more significant stage.

---
 rtl/full_subtractor_unit.sv | 109 ++++++++++
 tb/tb_full_subtractor_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_subtractor_unit.sv
// Registered ripple-borrow subtractor: {bout, diff} = a - b - bin, one result per accepted cycle.
// Define FULL_SUBTRACTOR_SAT_EN to clamp diff to zero on underflow and expose the sat flag.

module full_subtractor_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_br,
   output logic o_d,
   output logic o_br
);

   logic w_axb;

   assign w_axb = i_a ^ i_b;
   assign o_d   = w_axb ^ i_br;
   // Borrow out when b exceeds a outright, or they match and a borrow arrives.
   assign o_br  = (~i_a & i_b) | (~w_axb & i_br);

endmodule

module full_subtractor_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
`ifdef FULL_SUBTRACTOR_SAT_EN
   ,
   output logic             sat
`endif
);

   logic [WIDTH:0]   w_br;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_diff_next;
   logic             w_zero_next;

   logic             r_valid;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;

   assign w_br[0] = bin;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         full_subtractor_cell u_cell (
            .i_a  (a[gi]),
            .i_b  (b[gi]),
            .i_br (w_br[gi]),
            .o_d  (w_d[gi]),
            .o_br (w_br[gi+1])
         );
      end
   endgenerate

`ifdef FULL_SUBTRACTOR_SAT_EN
   logic r_sat;

   // bout keeps the true borrow; only the stored difference is clamped.
   assign w_diff_next = w_br[WIDTH] ? '0 : w_d;
`else
   assign w_diff_next = w_d;
`endif

   assign w_zero_next = (w_diff_next == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_diff <= w_diff_next;
            r_bout <= w_br[WIDTH];
            r_zero <= w_zero_next;
         end
      end
   end

`ifdef FULL_SUBTRACTOR_SAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (in_valid) begin
         r_sat <= w_br[WIDTH];
      end
   end

   assign sat = r_sat;
`endif

   assign out_valid = r_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign zero      = r_zero;

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Bench for full_subtractor_unit: four instances (WIDTH 1/4/8/16) checked against an
// integer-arithmetic reference model plus hand-derived constant vectors.

module tb_full_subtractor_unit;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;

   logic [15:0] ta   [N];
   logic [15:0] tbv  [N];
   logic        tbin [N];
   logic        tv   [N];

   logic [0:0]  a1, b1, d1;
   logic [3:0]  a4, b4, d4;
   logic [7:0]  a8, b8, d8;
   logic [15:0] a16, b16, d16;
   logic        ov1, ov4, ov8, ov16;
   logic        bo1, bo4, bo8, bo16;
   logic        z1, z4, z8, z16;

   logic [19:0] obs_all [N];

   logic [15:0] m_diff [N];
   logic        m_bout [N];
   logic        m_zero [N];
   logic        m_sat  [N];
   logic        m_ov   [N];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign a1  = ta[0][0:0];
   assign b1  = tbv[0][0:0];
   assign a4  = ta[1][3:0];
   assign b4  = tbv[1][3:0];
   assign a8  = ta[2][7:0];
   assign b8  = tbv[2][7:0];
   assign a16 = ta[3];
   assign b16 = tbv[3];

`ifdef FULL_SUBTRACTOR_SAT_EN
   logic s1, s4, s8, s16;
`else
   logic s1, s4, s8, s16;
   assign s1  = 1'b0;
   assign s4  = 1'b0;
   assign s8  = 1'b0;
   assign s16 = 1'b0;
`endif

   assign obs_all[0] = {ov1,  bo1,  z1,  s1,  15'd0, d1};
   assign obs_all[1] = {ov4,  bo4,  z4,  s4,  12'd0, d4};
   assign obs_all[2] = {ov8,  bo8,  z8,  s8,  8'd0,  d8};
   assign obs_all[3] = {ov16, bo16, z16, s16, d16};

   full_subtractor_unit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(tv[0]), .a(a1), .b(b1), .bin(tbin[0]),
      .out_valid(ov1), .diff(d1), .bout(bo1), .zero(z1)
`ifdef FULL_SUBTRACTOR_SAT_EN
      , .sat(s1)
`endif
   );

   full_subtractor_unit #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(tv[1]), .a(a4), .b(b4), .bin(tbin[1]),
      .out_valid(ov4), .diff(d4), .bout(bo4), .zero(z4)
`ifdef FULL_SUBTRACTOR_SAT_EN
      , .sat(s4)
`endif
   );

   full_subtractor_unit #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(tv[2]), .a(a8), .b(b8), .bin(tbin[2]),
      .out_valid(ov8), .diff(d8), .bout(bo8), .zero(z8)
`ifdef FULL_SUBTRACTOR_SAT_EN
      , .sat(s8)
`endif
   );

   full_subtractor_unit #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .in_valid(tv[3]), .a(a16), .b(b16), .bin(tbin[3]),
      .out_valid(ov16), .diff(d16), .bout(bo16), .zero(z16)
`ifdef FULL_SUBTRACTOR_SAT_EN
      , .sat(s16)
`endif
   );

   function automatic int wid(input int k);
      case (k)
         0:       return 1;
         1:       return 4;
         2:       return 8;
         default: return 16;
      endcase
   endfunction

   // Reference: plain signed integer subtraction; negative result means borrow.
   function automatic logic [17:0] ref_sub(input int w, input logic [15:0] x,
                                           input logic [15:0] y, input logic c);
      int          mask;
      int          t;
      logic        bo;
      logic        s;
      logic [15:0] d;
      mask = (1 << w) - 1;
      t    = (int'(x) & mask) - (int'(y) & mask) - (c ? 1 : 0);
      bo   = (t < 0);
      d    = 16'(t & mask);
      s    = 1'b0;
`ifdef FULL_SUBTRACTOR_SAT_EN
      if (bo) begin
         d = 16'd0;
         s = 1'b1;
      end
`endif
      return {s, bo, d};
   endfunction

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         tv[k]   = 1'b0;
         ta[k]   = 16'($urandom);
         tbv[k]  = 16'($urandom);
         tbin[k] = 1'($urandom);
      end
   endtask

   // One clock: inputs already set; model updates from the values sampled at the edge.
   task automatic cycle();
      logic [17:0] r;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (rst) begin
            m_diff[k] = 16'd0;
            m_bout[k] = 1'b0;
            m_zero[k] = 1'b0;
            m_sat[k]  = 1'b0;
            m_ov[k]   = 1'b0;
         end else begin
            if (tv[k]) begin
               r         = ref_sub(wid(k), ta[k], tbv[k], tbin[k]);
               m_diff[k] = r[15:0];
               m_bout[k] = r[16];
               m_sat[k]  = r[17];
               m_zero[k] = (r[15:0] == 16'd0);
            end
            m_ov[k] = tv[k];
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         tv[k]   = 1'b1;
         ta[k]   = 16'd1;
         tbv[k]  = 16'd0;
         tbin[k] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
         cycle();
         for (int k = 0; k < N; k++) begin
            n_vec++;
            if (obs_all[k] !== 20'h00000) begin
               n_err++;
               $display("FAIL reset w=%0d cyc=%0d: got %h want 00000", wid(k), c, obs_all[k]);
            end
         end
      end
      rst = 1'b0;
      idle_all();
      cycle();
   endtask

   task automatic test_w1_exhaustive();
      logic [1:0]  tt [8];
      logic [1:0]  e;
      logic [15:0] ed;
      logic        es;
      tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      idle_all();
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v       = 3'(i);
         tv[0]   = 1'b1;
         ta[0]   = {15'd0, v[2]};
         tbv[0]  = {15'd0, v[1]};
         tbin[0] = v[0];
         cycle();
         e  = tt[i];
         ed = {15'd0, e[1]};
         es = 1'b0;
`ifdef FULL_SUBTRACTOR_SAT_EN
         if (e[0]) begin
            ed = 16'd0;
            es = 1'b1;
         end
`endif
         n_vec++;
         if (obs_all[0] !== {1'b1, e[0], (ed == 16'd0), es, ed}) begin
            n_err++;
            $display("FAIL w1_truth abc=%b: got %h want %h", v, obs_all[0],
                     {1'b1, e[0], (ed == 16'd0), es, ed});
         end
      end
      tv[0] = 1'b0;
   endtask

   task automatic test_wrap();
      logic [19:0] want;
      idle_all();
      tv[2] = 1'b1; ta[2] = 16'h0000; tbv[2] = 16'h0001; tbin[2] = 1'b0;
      tv[3] = 1'b1; ta[3] = 16'h0000; tbv[3] = 16'hFFFF; tbin[3] = 1'b1;
      cycle();
`ifdef FULL_SUBTRACTOR_SAT_EN
      want = {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
`else
      want = {1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF};
`endif
      n_vec++;
      if (obs_all[2] !== want) begin
         n_err++;
         $display("FAIL w8_wrap: got %h want %h", obs_all[2], want);
      end
`ifdef FULL_SUBTRACTOR_SAT_EN
      want = {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
`else
      want = {1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
`endif
      n_vec++;
      if (obs_all[3] !== want) begin
         n_err++;
         $display("FAIL w16_extreme: got %h want %h", obs_all[3], want);
      end
   endtask

   task automatic test_w8_normal();
      idle_all();
      tv[2] = 1'b1; ta[2] = 16'h005A; tbv[2] = 16'h003C; tbin[2] = 1'b1;
      cycle();
      n_vec++;
      if (obs_all[2] !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h001D}) begin
         n_err++;
         $display("FAIL w8_normal_5a: got %h want %h", obs_all[2], {4'b1000, 16'h001D});
      end
      ta[2] = 16'h0010; tbv[2] = 16'h0010; tbin[2] = 1'b0;
      cycle();
      n_vec++;
      if (obs_all[2] !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
         n_err++;
         $display("FAIL w8_normal_eq: got %h want %h", obs_all[2], {4'b1010, 16'h0000});
      end
      tv[2] = 1'b0;
   endtask

   task automatic test_hold();
      idle_all();
      tv[1] = 1'b1; ta[1] = 16'h0007; tbv[1] = 16'h0002; tbin[1] = 1'b0;
      cycle();
      n_vec++;
      if (obs_all[1] !== {4'b1000, 16'h0005}) begin
         n_err++;
         $display("FAIL hold_load: got %h want %h", obs_all[1], {4'b1000, 16'h0005});
      end
      for (int c = 0; c < 3; c++) begin
         idle_all();
         cycle();
         n_vec++;
         if (obs_all[1] !== {4'b0000, 16'h0005}) begin
            n_err++;
            $display("FAIL hold_idle cyc=%0d: got %h want %h", c, obs_all[1], {4'b0000, 16'h0005});
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++) begin
         rst = (i == 4000) || ($urandom_range(0, 499) == 0);
         for (int k = 0; k < N; k++) begin
            tv[k]   = ($urandom_range(0, 7) != 0);
            ta[k]   = 16'($urandom);
            tbv[k]  = 16'($urandom);
            tbin[k] = 1'($urandom);
         end
         cycle();
         for (int k = 0; k < N; k++) begin
            n_vec++;
            if (rst) begin
               if (obs_all[k] !== 20'h00000) begin
                  n_err++;
                  $display("FAIL rand_reset w=%0d i=%0d: got %h want 00000", wid(k), i, obs_all[k]);
               end
            end else if (obs_all[k] !== {m_ov[k], m_bout[k], m_zero[k], m_sat[k], m_diff[k]}) begin
               n_err++;
               $display("FAIL rand w=%0d i=%0d: got %h want %h", wid(k), i, obs_all[k],
                        {m_ov[k], m_bout[k], m_zero[k], m_sat[k], m_diff[k]});
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle_all();
      #2;
      test_reset();
      test_w1_exhaustive();
      test_wrap();
      test_w8_normal();
      test_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
